fft_input_framer: RTL and testbench
===================================

FFT_INPUT_FRAMER -- requirements
Module: fft_input_framer

Interface
REQ-001 Parameters SHALL be: DW, 16, sample component width; N, 8, samples per frame (fixed; other values unsupported).
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 s_valid  input  1  upstream sample valid.
REQ-005 s_ready  output  1  framer can accept a sample this cycle.
REQ-006 s_re  input  DW  signed real part of sample.
REQ-007 s_im  input  DW  signed imaginary part of sample.
REQ-008 frame_xr  output  N*DW  real lanes to FFT; lane j = bits [DW*j +: DW].
REQ-009 frame_xi  output  N*DW  imaginary lanes to FFT, same lane mapping.
REQ-010 fft_start  output  1  frame on frame_xr/xi is valid; FFT runs while high.
REQ-011 fft_done  input  1  one-cycle completion pulse from FFT.
REQ-012 busy  output  1  high while fft_start high.

Function
REQ-013 Two frame banks (ping-pong) SHALL exist: one filling, one presented to FFT.
REQ-014 Sample transfer SHALL occur on a cycle with s_valid && s_ready; the sample is written to lane k of the fill bank, k = write index 0..7.
REQ-015 Write index SHALL increment per transfer and wrap 7 -> 0; on the transfer at index 7 the fill bank SHALL be marked full and filling SHALL switch to the other bank.
REQ-016 s_ready SHALL be low iff the current fill bank is full (both banks full); combinational from registered flags only, no dependency on s_valid.
REQ-017 Output FSM states: IDLE, RUN. IDLE -> RUN when a full bank exists; fft_start rises the cycle after the bank becomes full (1-cycle latency from 8th transfer).
REQ-018 In RUN, fft_start SHALL stay high and frame_xr/xi SHALL hold stable bank contents until fft_done is sampled high.
REQ-019 On fft_done in RUN: that bank SHALL be released (not full) and fft_start SHALL drop next cycle; if the other bank is already full, FSM SHALL return to RUN after exactly one IDLE cycle (fft_start low for one cycle between frames).
REQ-020 fft_done in IDLE SHALL be ignored.
REQ-021 Bank release and fill-complete in the same cycle SHALL both take effect; no sample lost, s_ready high next cycle.
REQ-022 Frames SHALL be presented in arrival order; no sample SHALL ever be dropped or overwritten.
REQ-023 Samples SHALL be stored unmodified (no scaling, saturation or sign change).

Reset
REQ-024 On rst: write index 0, fill bank 0, both banks empty, FSM IDLE, fft_start 0, busy 0, s_ready 1, frame_xr/xi 0.
REQ-025 rst mid-frame or mid-RUN SHALL discard all partial and pending frames; no fft_start after release until 8 new samples arrive.

Configuration
REQ-026 Macro FFT_FRAMER_BITREV_EN: when defined, sample k SHALL be stored in lane bitrev3(k) (0,4,2,6,1,5,3,7); when undefined, lane k (natural order).

Structure
REQ-027 Shared package fft_pkg SHALL hold DW, N, the FSM state enum and the bitrev3 function.
REQ-028 One sub-module fft_frame_bank (one N*DW complex register bank with lane write-enable and full flag) SHALL be instantiated twice.

Verification
REQ-029 8 back-to-back samples re=1..8, im=-1..-8, fft_done never -> fft_start high cycle after 8th; frame_xr lanes 0..7 = 1..8 (natural) or 1,5,3,7,2,6,4,8 with BITREV.
REQ-030 Continue with 8 more samples while RUN -> accepted; 17th sample sees s_ready=0 until fft_done pulse; first frame_xr values unchanged throughout RUN.
REQ-031 fft_done pulse with second bank full -> fft_start low exactly one cycle, then high with second frame (re=9..16).
REQ-032 fft_done pulse on same cycle as 8th transfer of next frame -> no stall, s_ready high next cycle, next frame started after one IDLE cycle.
REQ-033 rst asserted after 5 samples and again during RUN -> all outputs at reset values asynchronously; next fft_start only after 8 fresh samples.
REQ-034 s_valid toggling randomly, fft_done pulsed 4-10 cycles after each start, 100 frames -> scoreboard matches every frame, in order, none dropped.

Source files
------------

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT input framer:
//   DW          - sample component width (signed real / imaginary)
//   N           - samples per frame (the framer is built for N = 8 only)
//   IW          - width of the in-frame write index
//   fsm_state_e - output FSM states (IDLE / RUN)
//   bitrev3()   - 3-bit bit reversal used when FFT_FRAMER_BITREV_EN is defined
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int DW = 16;
    localparam int N  = 8;
    localparam int IW = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_state_e;

    // Reverse the three index bits: 0,1,2,3,4,5,6,7 -> 0,4,2,6,1,5,3,7.
    function automatic logic [IW-1:0] bitrev3(input logic [IW-1:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// ---------------------------------------------------------------------------
// fft_frame_bank
// One frame bank: N complex lanes of DW bits each plus a "full" flag.
//   clk, rst     - clock, asynchronous active-high reset
//   we_i         - write the sample on re_i/im_i into lane lane_i
//   lane_i       - target lane of the write
//   re_i, im_i   - sample components, stored unmodified
//   set_full_i   - mark the bank full (last sample of a frame written)
//   clr_full_i   - release the bank after the FFT consumed it
//   xr_o, xi_o   - lane contents, lane j = bits [DW*j +: DW]
//   full_o       - bank holds a complete, not yet consumed frame
// ---------------------------------------------------------------------------
module fft_frame_bank #(
    parameter int DW = fft_pkg::DW,
    parameter int N  = fft_pkg::N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic [$clog2(N)-1:0] lane_i,
    input  logic [DW-1:0]        re_i,
    input  logic [DW-1:0]        im_i,
    input  logic                 set_full_i,
    input  logic                 clr_full_i,
    output logic [N*DW-1:0]      xr_o,
    output logic [N*DW-1:0]      xi_o,
    output logic                 full_o
);

    logic [N*DW-1:0] xr_q;
    logic [N*DW-1:0] xi_q;
    logic            full_q;
    logic            full_d;

    // Next value of the full flag; set and clear never coincide because a
    // full bank is never written and an empty bank is never released.
    always_comb begin
        full_d = full_q;
        if (set_full_i) begin
            full_d = 1'b1;
        end else if (clr_full_i) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Lane storage and full flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xr_q   <= '0;
            xi_q   <= '0;
            full_q <= 1'b0;
        end else begin
            if (we_i) begin
                xr_q[int'(lane_i)*DW +: DW] <= re_i;
                xi_q[int'(lane_i)*DW +: DW] <= im_i;
            end
            full_q <= full_d;
        end
    end

    assign xr_o   = xr_q;
    assign xi_o   = xi_q;
    assign full_o = full_q;

endmodule

// File: rtl/fft_input_framer.sv
// ---------------------------------------------------------------------------
// fft_input_framer
// Collects a stream of complex samples into 8-sample frames using two
// ping-pong banks and hands complete frames to an FFT in arrival order.
//   clk, rst           - clock, asynchronous active-high reset
//   s_valid / s_ready  - upstream sample handshake
//   s_re, s_im         - signed sample components
//   frame_xr, frame_xi - presented frame, lane j = bits [DW*j +: DW]
//   fft_start          - frame valid, held high until fft_done
//   fft_done           - one-cycle completion pulse from the FFT
//   busy               - mirrors fft_start
// Build option: define FFT_FRAMER_BITREV_EN to store sample k in lane
// bitrev3(k) instead of lane k.
// ---------------------------------------------------------------------------
module fft_input_framer #(
    parameter int DW = fft_pkg::DW,
    parameter int N  = fft_pkg::N
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_re,
    input  logic [DW-1:0]   s_im,
    output logic [N*DW-1:0] frame_xr,
    output logic [N*DW-1:0] frame_xi,
    output logic            fft_start,
    input  logic            fft_done,
    output logic            busy
);

    import fft_pkg::*;

    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic          fill_bank_q, fill_bank_d;   // bank receiving samples
    logic          pres_bank_q, pres_bank_d;   // oldest bank, shown to FFT
    fsm_state_e    state_q, state_d;
    logic          start_q, start_d;

    logic [1:0]      full_s;
    logic [1:0]      we_s;
    logic [1:0]      set_full_s;
    logic [1:0]      clr_full_s;
    logic [N*DW-1:0] xr_s [2];
    logic [N*DW-1:0] xi_s [2];
    logic            xfer_s;
    logic [IW-1:0]   lane_s;

    // The fill bank is only blocked when it still holds an unconsumed frame,
    // which can only happen when both banks are full.
    assign s_ready = ~full_s[fill_bank_q];
    assign xfer_s  = s_valid & s_ready;

`ifdef FFT_FRAMER_BITREV_EN
    assign lane_s = bitrev3(wr_idx_q);
`else
    assign lane_s = wr_idx_q;
`endif

    // Fill-side pointer update and FSM next state. When no bank is full the
    // presented bank equals the fill bank, so a frame completing in IDLE is
    // seen through set_full_s and started with one cycle of latency.
    always_comb begin
        wr_idx_d    = wr_idx_q;
        fill_bank_d = fill_bank_q;
        pres_bank_d = pres_bank_q;
        state_d     = state_q;
        we_s        = 2'b00;
        set_full_s  = 2'b00;
        clr_full_s  = 2'b00;

        if (xfer_s) begin
            we_s[fill_bank_q] = 1'b1;
            wr_idx_d          = wr_idx_q + 3'd1;
            if (wr_idx_q == 3'd7) begin
                set_full_s[fill_bank_q] = 1'b1;
                fill_bank_d             = ~fill_bank_q;
            end else begin
                fill_bank_d = fill_bank_q;
            end
        end else begin
            wr_idx_d = wr_idx_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (full_s[pres_bank_q] || set_full_s[pres_bank_q]) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Always pass through IDLE so fft_start shows a gap.
                if (fft_done) begin
                    clr_full_s[pres_bank_q] = 1'b1;
                    pres_bank_d             = ~pres_bank_q;
                    state_d                 = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        start_d = (state_d == ST_RUN);
    end

    // FSM state and registered start output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

    // Write index and bank pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx_q    <= 3'd0;
            fill_bank_q <= 1'b0;
            pres_bank_q <= 1'b0;
        end else begin
            wr_idx_q    <= wr_idx_d;
            fill_bank_q <= fill_bank_d;
            pres_bank_q <= pres_bank_d;
        end
    end

    fft_frame_bank #(.DW(DW), .N(N)) u_bank0 (
        .clk        (clk),
        .rst        (rst),
        .we_i       (we_s[0]),
        .lane_i     (lane_s),
        .re_i       (s_re),
        .im_i       (s_im),
        .set_full_i (set_full_s[0]),
        .clr_full_i (clr_full_s[0]),
        .xr_o       (xr_s[0]),
        .xi_o       (xi_s[0]),
        .full_o     (full_s[0])
    );

    fft_frame_bank #(.DW(DW), .N(N)) u_bank1 (
        .clk        (clk),
        .rst        (rst),
        .we_i       (we_s[1]),
        .lane_i     (lane_s),
        .re_i       (s_re),
        .im_i       (s_im),
        .set_full_i (set_full_s[1]),
        .clr_full_i (clr_full_s[1]),
        .xr_o       (xr_s[1]),
        .xi_o       (xi_s[1]),
        .full_o     (full_s[1])
    );

    assign frame_xr  = pres_bank_q ? xr_s[1] : xr_s[0];
    assign frame_xi  = pres_bank_q ? xi_s[1] : xi_s[0];
    assign fft_start = start_q;
    assign busy      = start_q;

endmodule

// File: tb/tb_fft_input_framer.sv
// ---------------------------------------------------------------------------
// tb_fft_input_framer
// Directed cycle table for handshake / start timing / frame contents, hand
// sequences for asynchronous reset, and a randomised 100-frame scoreboard run.
// Inputs are driven and outputs checked on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fft_input_framer;

    localparam int DW = 16;
    localparam int N  = 8;

    logic            clk;
    logic            rst;
    logic            s_valid;
    logic            s_ready;
    logic [DW-1:0]   s_re;
    logic [DW-1:0]   s_im;
    logic [N*DW-1:0] frame_xr;
    logic [N*DW-1:0] frame_xi;
    logic            fft_start;
    logic            fft_done;
    logic            busy;

    int n_tests;
    int n_fail;

    fft_input_framer #(.DW(DW), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_re      (s_re),
        .s_im      (s_im),
        .frame_xr  (frame_xr),
        .frame_xi  (frame_xi),
        .fft_start (fft_start),
        .fft_done  (fft_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One table row = one clock cycle: outputs expected at the falling edge,
    // then the inputs applied for the following rising edge.
    typedef struct {
        logic        v;
        logic [15:0] re;
        logic        done;
        logic        ready;
        logic        start;
        int          fbase;   // 0: no frame check, else sample k = fbase + k
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v, input int re, input logic done,
                                input logic ready, input logic start, input int fbase);
        vec_t e;
        e.v = v; e.re = 16'(re); e.done = done;
        e.ready = ready; e.start = start; e.fbase = fbase;
        vecs.push_back(e);
    endfunction

    // Which sample index ends up in lane j.
    function automatic int lane_src(input int j);
`ifdef FFT_FRAMER_BITREV_EN
        case (j)
            0: return 0;
            1: return 4;
            2: return 2;
            3: return 6;
            4: return 1;
            5: return 5;
            6: return 3;
            7: return 7;
            default: return 0;
        endcase
`else
        return j;
`endif
    endfunction

    function automatic logic [N*DW-1:0] exp_xr(input int base);
        logic [N*DW-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) r[j*DW +: DW] = 16'(base + lane_src(j));
        return r;
    endfunction

    function automatic logic [N*DW-1:0] exp_xi(input int base);
        logic [N*DW-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) r[j*DW +: DW] = 16'(-(base + lane_src(j)));
        return r;
    endfunction

    task automatic chk(input string nm, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_ready"}, 128'(s_ready), 128'(1));
        chk({nm, "_start"}, 128'(fft_start), 128'(0));
        chk({nm, "_busy"}, 128'(busy), 128'(0));
        chk({nm, "_xr"}, frame_xr, '0);
        chk({nm, "_xi"}, frame_xi, '0);
    endtask

    // Drive n consecutive samples base, base+1, ... one per cycle (im = -re).
    task automatic feed(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_re    = 16'(base + i);
            s_im    = 16'(-(base + i));
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Random scoreboard state
    logic [15:0] q_re[$];
    logic [15:0] q_im[$];

    initial begin
        int pushed, frames, cyc, wait_cnt;
        bit started;
        logic [N*DW-1:0] er, ei;

        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_re     = '0;
        s_im     = '0;
        fft_done = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // ---------------- directed cycle table ----------------
        for (int i = 1; i <= 8; i++) add(1'b1, i, 1'b0, 1'b1, 1'b0, 0);
        for (int i = 9; i <= 16; i++) add(1'b1, i, 1'b0, 1'b1, 1'b1, (i == 9) ? 1 : 0);
        add(1'b1, 17, 1'b0, 1'b0, 1'b1, 1);      // both banks full: stall
        add(1'b1, 17, 1'b1, 1'b0, 1'b1, 1);      // done; first frame unchanged
        add(1'b1, 17, 1'b0, 1'b1, 1'b0, 0);      // single IDLE cycle, 17 accepted
        for (int i = 18; i <= 23; i++) add(1'b1, i, 1'b0, 1'b1, 1'b1, (i == 18) ? 9 : 0);
        add(1'b1, 24, 1'b1, 1'b1, 1'b1, 9);      // 8th transfer and done together
        add(1'b1, 25, 1'b0, 1'b1, 1'b0, 0);      // no stall after coincident release
        add(1'b0, 0, 1'b0, 1'b1, 1'b1, 17);      // third frame started
        add(1'b0, 0, 1'b1, 1'b1, 1'b1, 17);
        add(1'b0, 0, 1'b1, 1'b1, 1'b0, 0);       // done in IDLE is ignored
        add(1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
        add(1'b0, 0, 1'b0, 1'b1, 1'b0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), 128'(s_ready), 128'(vecs[i].ready));
            chk($sformatf("v%0d_start", i), 128'(fft_start), 128'(vecs[i].start));
            chk($sformatf("v%0d_busy", i), 128'(busy), 128'(vecs[i].start));
            if (vecs[i].fbase != 0) begin
                chk($sformatf("v%0d_xr", i), frame_xr, exp_xr(vecs[i].fbase));
                chk($sformatf("v%0d_xi", i), frame_xi, exp_xi(vecs[i].fbase));
            end
            s_valid  = vecs[i].v;
            s_re     = vecs[i].re;
            s_im     = 16'(-vecs[i].re);
            fft_done = vecs[i].done;
        end
        @(negedge clk);
        fft_done = 1'b0;
        s_valid  = 1'b0;

        // ---------------- reset after 5 samples ----------------
        feed(100, 5);
        #2 rst = 1'b1;
        #1 chk_reset_vals("rst_partial");
        @(negedge clk);
        rst = 1'b0;
        feed(200, 7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_partial_no_start", 128'(fft_start), 128'(0));
        end
        feed(207, 1);
        chk("fresh_start", 128'(fft_start), 128'(1));
        chk("fresh_xr", frame_xr, exp_xr(200));

        // ---------------- reset during RUN with a pending frame ----------------
        feed(300, 8);
        chk("pending_stall", 128'(s_ready), 128'(0));
        #2 rst = 1'b1;
        #1 chk_reset_vals("rst_run");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_run_no_start", 128'(fft_start), 128'(0));
        end
        feed(400, 8);
        chk("rst_run_restart", 128'(fft_start), 128'(1));
        chk("rst_run_xi", frame_xi, exp_xi(400));

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // ---------------- random traffic, 100 frames ----------------
        pushed   = 0;
        frames   = 0;
        cyc      = 0;
        started  = 1'b0;
        wait_cnt = 0;
        while (frames < 100 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            fft_done = 1'b0;
            if (!started && fft_start) begin
                if (q_re.size() < N) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rand_frame%0d started with %0d queued samples", frames, q_re.size());
                end else begin
                    for (int j = 0; j < N; j++) begin
                        er[j*DW +: DW] = q_re[lane_src(j)];
                        ei[j*DW +: DW] = q_im[lane_src(j)];
                    end
                    for (int j = 0; j < N; j++) begin
                        void'(q_re.pop_front());
                        void'(q_im.pop_front());
                    end
                    chk($sformatf("rand_frame%0d_xr", frames), frame_xr, er);
                    chk($sformatf("rand_frame%0d_xi", frames), frame_xi, ei);
                end
                frames++;
                started  = 1'b1;
                wait_cnt = $urandom_range(4, 10);
            end else if (started) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    fft_done = 1'b1;
                    started  = 1'b0;
                end
            end
            if (pushed < 100 * N) begin
                s_valid = 1'($urandom_range(0, 1));
                s_re    = 16'($urandom);
                s_im    = 16'($urandom);
                if (s_valid && s_ready) begin
                    q_re.push_back(s_re);
                    q_im.push_back(s_im);
                    pushed++;
                end
            end else begin
                s_valid = 1'b0;
            end
        end
        chk("rand_frame_count", 128'(frames), 128'(100));
        chk("rand_queue_empty", 128'(q_re.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
